// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

  // Datapath geometry of the 32x32 register file
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  // Width of the requester index / round-robin pointer (covers up to 4 requesters)
  localparam int GIW = 2;

  // Controller operating state
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requester slots on the shared write port
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_DBG = 2;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter: searches upward from ptr,
// wrapping modulo NREQ, and grants the first valid requester.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GIW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [GIW-1:0]  grant_idx,
  output logic            any
);

  logic [NREQ-1:0] grant_s;
  logic [GIW-1:0]  idx_s;
  logic            found_s;

  // Priority search: offset k from the pointer is examined before offset k+1
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found_s && valid[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          found_s    = 1'b1;
          grant_s[i] = 1'b1;
          idx_s      = GIW'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
  assign any       = found_s;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the three-port register file: scrubs x1..x31
// after reset, then shares WE3/A3/WD3 among NREQ requesters round-robin.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int AW    = regfile_pkg::AW,
  parameter int NREQ  = 3,
  parameter int SCRUB = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 WE3,
  output logic [AW-1:0]        A3,
  output logic [XLEN-1:0]      WD3,
  output logic                 init_done,
  output logic [1:0]           grant_id
);

  // Highest register address; the scrub counter wraps to 0 after it
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_t          state_r;
  logic [GIW-1:0]  ptr_r;
  logic [AW-1:0]   cnt_r;
  logic            we3_r;
  logic [AW-1:0]   a3_r;
  logic [XLEN-1:0] wd3_r;
  logic            init_done_r;
  logic [GIW-1:0]  grant_id_r;

  logic [NREQ-1:0] arb_valid_s;
  logic [NREQ-1:0] grant_s;
  logic [GIW-1:0]  gidx_s;
  logic            any_s;
  logic [AW-1:0]   sel_addr_s;
  logic [XLEN-1:0] sel_data_s;
  logic [GIW-1:0]  ptr_nxt_s;

  // Requests are invisible to the arbiter until the scrub has completed
  always_comb begin
    if (state_r == ST_RUN) begin
      arb_valid_s = req_valid;
    end else begin
      arb_valid_s = '0;
    end
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .valid     (arb_valid_s),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (gidx_s),
    .any       (any_s)
  );

  // Select the granted requester's address and data slices
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        sel_addr_s = req_addr[i*AW +: AW];
        sel_data_s = req_data[i*XLEN +: XLEN];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Pointer moves one past the winner so it gets lowest priority next time
  always_comb begin
    if (gidx_s == GIW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gidx_s + GIW'(1);
    end
  end

  // State, scrub counter, pointer and registered write-port outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_INIT;
      ptr_r       <= '0;
      cnt_r       <= AW'(1);
      we3_r       <= 1'b0;
      a3_r        <= '0;
      wd3_r       <= '0;
      init_done_r <= 1'b0;
      grant_id_r  <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (SCRUB != 0) begin
            if (cnt_r == '0) begin
              // Counter wrapped past the last address: scrub finished
              we3_r       <= 1'b0;
              init_done_r <= 1'b1;
              state_r     <= ST_RUN;
            end else begin
              we3_r <= 1'b1;
              a3_r  <= cnt_r;
              wd3_r <= '0;
              if (cnt_r == LAST_ADDR) begin
                cnt_r <= '0;
              end else begin
                cnt_r <= cnt_r + AW'(1);
              end
            end
          end else begin
            we3_r       <= 1'b0;
            init_done_r <= 1'b1;
            state_r     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (any_s) begin
            // x0 is hardwired zero: accept the request but suppress the write
            we3_r      <= (sel_addr_s != '0);
            a3_r       <= sel_addr_s;
            wd3_r      <= sel_data_s;
            grant_id_r <= gidx_s;
            ptr_r      <= ptr_nxt_s;
          end else begin
            we3_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_INIT;
          we3_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = grant_s;
  assign WE3       = we3_r;
  assign A3        = a3_r;
  assign WD3       = wd3_r;
  assign init_done = init_done_r;
  assign grant_id  = 2'(grant_id_r);

endmodule
